// File: rtl/regfile_arbiter_pkg.sv
// Shared defaults and ownership-FSM encoding for the register-file arbiter.
package regfile_arbiter_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int ADDR_W_DEF   = 4;
   localparam int LOCK_MAX_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/regfile_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright; on contention the
// requester that was not granted most recently wins.
module regfile_rr_pick (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_gnt ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter driving a register file (1-cycle read latency).
// Define REGFILE_ARBITER_LOCK_EN to enable lock ownership (IDLE/OWN0/OWN1 FSM).
module regfile_arbiter
   import regfile_arbiter_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] aa0,
   input  logic [ADDR_W-1:0] ba0,
   input  logic [ADDR_W-1:0] da0,
   input  logic [DATA_W-1:0] d0,
   input  logic              lock0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] aa1,
   input  logic [ADDR_W-1:0] ba1,
   input  logic [ADDR_W-1:0] da1,
   input  logic [DATA_W-1:0] d1,
   input  logic              lock1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rf_D,
   output logic [ADDR_W-1:0] rf_DA,
   output logic [ADDR_W-1:0] rf_AA,
   output logic [ADDR_W-1:0] rf_BA,
   output logic              rf_RW,
   output logic              rf_en,
   output logic              rf_rst,
   output arb_state_t        state
);

   // gntN is a same-cycle combinational answer to reqN; rvalidN follows one
   // cycle later for every granted cycle, except that reset masks both.
   logic [1:0] req, pick, gnt, gnt_v;
   logic [1:0] rvalid_q;
   logic       last_gnt;
   arb_state_t state_q;

   assign req = {req1, req0};

   regfile_rr_pick u_pick (
      .req      (req),
      .last_gnt (last_gnt),
      .gnt      (pick)
   );

`ifdef REGFILE_ARBITER_LOCK_EN
   localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

   arb_state_t       state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       lock;
   logic             own;
   logic             rearb;

   assign lock = {lock1, lock0};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = pick;
      own     = (state_q == OWN1);
      rearb   = 1'b1;
      if ((state_q == OWN0 || state_q == OWN1) && req[own]) begin
         rearb = 1'b0;
         gnt   = own ? 2'b10 : 2'b01;
         cnt_d = cnt_q + 1'b1;
         if (!lock[own] || cnt_d >= CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end
      // Owner dropped its request (or no owner): arbitrate this cycle as idle.
      if (rearb) begin
         state_d = IDLE;
         cnt_d   = '0;
         if (LOCK_MAX > 1) begin
            if (pick[0] && lock0) begin
               state_d = OWN0;
               cnt_d   = CNT_W'(1);
            end else if (pick[1] && lock1) begin
               state_d = OWN1;
               cnt_d   = CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   logic unused_lock;
   localparam int unused_lock_max = LOCK_MAX;

   assign unused_lock = lock0 ^ lock1;
   assign state_q     = IDLE;
   assign gnt         = pick;
`endif

   assign gnt_v = rst ? 2'b00 : gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= 1'b1;
         rvalid_q <= 2'b00;
      end else begin
         if (|gnt_v) last_gnt <= gnt_v[1];
         rvalid_q <= gnt_v;
      end
   end

   assign gnt0    = gnt_v[0];
   assign gnt1    = gnt_v[1];
   assign rvalid0 = rvalid_q[0] & ~rst;
   assign rvalid1 = rvalid_q[1] & ~rst;
   assign state   = state_q;

   // Reset enables the register file so its own clear takes effect.
   always_comb begin
      rf_rst = rst;
      rf_en  = rst;
      rf_RW  = 1'b0;
      rf_AA  = '0;
      rf_BA  = '0;
      rf_DA  = '0;
      rf_D   = '0;
      if (gnt_v[0]) begin
         rf_en = 1'b1;
         rf_RW = wr0;
         rf_AA = aa0;
         rf_BA = ba0;
         rf_DA = da0;
         rf_D  = d0;
      end else if (gnt_v[1]) begin
         rf_en = 1'b1;
         rf_RW = wr1;
         rf_AA = aa1;
         rf_BA = ba1;
         rf_DA = da1;
         rf_D  = d1;
      end
   end

endmodule
